irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 91 +++++++++
 tb/tb_irq_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-triggered interrupt controller with pending bits, lost-edge counter and claim/complete FSM (round-robin when IRQ_CTRL_RR_EN is defined)
module irq_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [N_SRC-1:0] irq_en,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [7:0]       lost_cnt
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;
  state_t state_q, state_d;
  logic [N_SRC-1:0] src_q, pend_q, pend_d, rise, req, clr;
  logic [ID_W-1:0] id_q, id_d, sel;
  logic [7:0] lost_q, lost_d;
  logic int_q, claim, lost;
  assign rise   = src_irq & ~src_q;
  assign req    = pend_q & irq_en;
  assign claim  = (state_q == ASSERT) && irq_ack;
  assign clr    = claim ? ({{(N_SRC-1){1'b0}}, 1'b1} << id_q) : '0;
  assign pend_d = (pend_q & ~clr) | rise;
  assign lost   = |(rise & pend_q & ~clr);
  assign lost_d = (lost && lost_q != 8'hFF) ? lost_q + 8'd1 : lost_q;
`ifdef IRQ_CTRL_RR_EN
  logic [ID_W-1:0] rr_q, rr_d, idx;
  assign rr_d = claim ? ID_W'((int'(id_q) + 1) % N_SRC) : rr_q;
  // round-robin pick: scan backwards so the first set index at or after rr_q wins
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_q) + k) % N_SRC);
      if (req[idx]) sel = idx;
    end
  end
  // rotation pointer advances past each claimed source
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_q <= '0;
    else rr_q <= rr_d;
  end
`else
  // fixed priority pick: lowest set index wins
  always_comb begin
    sel = '0;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (req[k]) sel = ID_W'(k);
  end
`endif
  // claim/complete FSM next state; index latched only when leaving IDLE
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE:    if (|req) begin
                 state_d = ASSERT;
                 id_d    = sel;
               end
      ASSERT:  if (irq_ack) state_d = SERVICE;
      SERVICE: if (irq_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, edge detector, pending bits, counter and registered request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      src_q   <= '0;
      pend_q  <= '0;
      id_q    <= '0;
      lost_q  <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_irq;
      pend_q  <= pend_d;
      id_q    <= id_d;
      lost_q  <= lost_d;
      int_q   <= (state_d == ASSERT);
    end
  end
  assign interrupt = int_q;
  assign irq_id    = id_q;
  assign pending   = pend_q;
  assign lost_cnt  = lost_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl (expected ids queued at stimulus, popped when interrupt presents)
module tb_irq_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] src_irq = '0, irq_en = '0;
  logic irq_ack = 1'b0, irq_done = 1'b0;
  logic interrupt;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [7:0] lost_cnt;
  int checks = 0, errors = 0;
  int exp_q[$];
  irq_ctrl dut (
    .clk(clk), .rstn(rstn), .src_irq(src_irq), .irq_en(irq_en),
    .irq_ack(irq_ack), .irq_done(irq_done), .interrupt(interrupt),
    .irq_id(irq_id), .pending(pending), .lost_cnt(lost_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [3:0] m);
    src_irq = m;
    tick();
    src_irq = '0;
  endtask
  task automatic service();
    int n, e;
    n = 0;
    while (!interrupt && n < 20) begin
      tick();
      n++;
    end
    check("irq_seen", interrupt, 1);
    e = exp_q.size() != 0 ? exp_q.pop_front() : -1;
    check("irq_id", irq_id, e);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("int_after_ack", interrupt, 0);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2;
    check("rst_int", interrupt, 0);
    check("rst_id", irq_id, 0);
    check("rst_pend", pending, 0);
    check("rst_lost", lost_cnt, 0);
    tick();
    rstn = 1'b1;
    tick();
    irq_en = 4'hF;
    exp_q.push_back(2);
    pulse(4'b0100);
    check("single_pend", pending, 4'b0100);
    check("single_int0", interrupt, 0);
    tick();
    check("single_int1", interrupt, 1);
    service();
    check("single_pend_clr", pending, 0);
    check("single_idle", interrupt, 0);
    exp_q.push_back(1);
    pulse(4'b0010);
    service();
    pulse(4'b1010);
    check("simul_pend", pending, 4'b1010);
`ifdef IRQ_CTRL_RR_EN
    exp_q.push_back(3);
    exp_q.push_back(1);
    service();
    check("simul_pend_rest", pending, 4'b0010);
`else
    exp_q.push_back(1);
    exp_q.push_back(3);
    service();
    check("simul_pend_rest", pending, 4'b1000);
`endif
    service();
    check("simul_pend_clr", pending, 0);
    irq_en = 4'h0;
    pulse(4'b0001);
    check("mask_pend", pending, 4'b0001);
    tick();
    tick();
    check("mask_int0", interrupt, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_ignored", pending, 4'b0001);
    irq_en = 4'b0001;
    tick();
    check("mask_int1", interrupt, 1);
    irq_en = 4'h0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check("assert_holds", interrupt, 1);
    irq_en = 4'hF;
    exp_q.push_back(0);
    service();
    irq_en = 4'h0;
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0010);
      tick();
    end
    check("lost_2", lost_cnt, 2);
    check("lost_pend", pending, 4'b0010);
    for (int i = 0; i < 297; i++) begin
      pulse(4'b0010);
      tick();
    end
    check("lost_sat", lost_cnt, 255);
    irq_en = 4'hF;
    exp_q.push_back(1);
    service();
    pulse(4'b1100);
    tick();
    check("rst_pre_int", interrupt, 1);
    check("rst_pre_id", irq_id, 2);
    #2;
    rstn = 1'b0;
    src_irq = 4'b0001;
    #1;
    check("async_int", interrupt, 0);
    check("async_pend", pending, 0);
    check("async_lost", lost_cnt, 0);
    check("async_id", irq_id, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("held_rise", pending, 4'b0001);
    src_irq = '0;
    exp_q.push_back(0);
    service();
    pulse(4'b0010);
    tick();
    check("coll_int", interrupt, 1);
    check("coll_id", irq_id, 1);
    src_irq = 4'b0010;
    irq_ack = 1'b1;
    tick();
    src_irq = '0;
    irq_ack = 1'b0;
    check("coll_pend", pending, 4'b0010);
    check("coll_lost", lost_cnt, 0);
    check("coll_int_ack", interrupt, 0);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    check("coll_turn0", interrupt, 0);
    tick();
    check("coll_turn1", interrupt, 1);
    exp_q.push_back(1);
    service();
    check("sb_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
